// File: rtl/seg7_pkg.sv
// Shared active-low 7-segment encoding, bit order {g,f,e,d,c,b,a}, for display driver and capture.
// Definitions only: no timing, no flow control.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Bit order of seg_t, MSB first; a segment is lit when its bit is 0.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam logic [3:0] SEG_BLANK_BCD = 4'hF;
    localparam logic [3:0] SEG_ERR_BCD   = 4'hE;

    typedef struct packed {
        logic [3:0] bcd;
        logic       invalid;
    } bcd_dec_t;

    typedef struct packed {
        logic [3:0] an;
        seg_t       seg;
    } scan_t;

    // A digit is being driven only when exactly one active-low anode is asserted.
    function automatic logic an_is_active(input logic [3:0] an);
        return $onehot(~an);
    endfunction

    function automatic logic [1:0] an_low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder; blank maps to F, anything unknown to E + invalid.
// Zero latency, no flow control.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  seg_t     seg_dat,
    output bcd_dec_t dec_dat
);

    always_comb begin
        dec_dat = '{bcd: SEG_ERR_BCD, invalid: 1'b1};
        case (seg_dat)
            SEG_0:     dec_dat = '{bcd: 4'd0, invalid: 1'b0};
            SEG_1:     dec_dat = '{bcd: 4'd1, invalid: 1'b0};
            SEG_2:     dec_dat = '{bcd: 4'd2, invalid: 1'b0};
            SEG_3:     dec_dat = '{bcd: 4'd3, invalid: 1'b0};
            SEG_4:     dec_dat = '{bcd: 4'd4, invalid: 1'b0};
            SEG_5:     dec_dat = '{bcd: 4'd5, invalid: 1'b0};
            SEG_6:     dec_dat = '{bcd: 4'd6, invalid: 1'b0};
            SEG_7:     dec_dat = '{bcd: 4'd7, invalid: 1'b0};
            SEG_8:     dec_dat = '{bcd: 4'd8, invalid: 1'b0};
            SEG_9:     dec_dat = '{bcd: 4'd9, invalid: 1'b0};
            SEG_BLANK: dec_dat = '{bcd: SEG_BLANK_BCD, invalid: 1'b0};
            default:   dec_dat = '{bcd: SEG_ERR_BCD, invalid: 1'b1};
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed anode/segment bus, captures each digit after a stable dwell, publishes 4-digit frames.
// Latency: 2-flop sync + STABLE samples to capture, frame one cycle later; observer only, no backpressure.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE  = 16,
    parameter int TIMEOUT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an_in,
    input  logic [6:0] seg_in,
    output logic [3:0] out3,
    output logic [3:0] out2,
    output logic [3:0] out1,
    output logic [3:0] out0,
    output logic [3:0] invalid,
    output logic       frame_valid,
    output logic       stale
);

    localparam int SCW = $clog2(STABLE);
    localparam int TOW = $clog2(TIMEOUT + 1);

    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE - 1);
    localparam logic [SCW-1:0] STAB_PRE  = SCW'(STABLE - 2);
    localparam logic [TOW-1:0] TMO_MAX   = TOW'(TIMEOUT);
    localparam logic [TOW-1:0] TMO_PRE   = TOW'(TIMEOUT - 1);

    scan_t             sync1_q, sync1_d;
    scan_t             sync2_q, sync2_d;
    scan_t             prev_q, prev_d;
    logic [SCW-1:0]    stab_cnt_q, stab_cnt_d;
    logic [TOW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [3:0]        seen_q, seen_d;
    logic [3:0][3:0]   shadow_q, shadow_d;
    logic [3:0]        shadow_inv_q, shadow_inv_d;
    logic [3:0][3:0]   out_q, out_d;
    logic [3:0]        invalid_q, invalid_d;
    logic              frame_valid_q, frame_valid_d;
    logic              stale_q, stale_d;

    bcd_dec_t          dec;
    logic              active;
    logic              same;
    logic              capture;
    logic [1:0]        dig_idx;
    logic [3:0]        seen_acc;

    seg7_to_bcd u_dec (
        .seg_dat (sync2_q.seg),
        .dec_dat (dec)
    );

    always_comb begin
        sync1_d = '{an: an_in, seg: seg_in};
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        active  = an_is_active(sync2_q.an);
        dig_idx = an_low_index(sync2_q.an);
        same    = (sync2_q == prev_q);

        // Counter holds (equal samples so far - 1); capture fires once, on the STABLE-th sample.
        stab_cnt_d = '0;
        capture    = 1'b0;
        if (active && same) begin
            stab_cnt_d = (stab_cnt_q == STAB_LAST) ? stab_cnt_q : stab_cnt_q + SCW'(1);
            capture    = (stab_cnt_q == STAB_PRE);
        end

        shadow_d     = shadow_q;
        shadow_inv_d = shadow_inv_q;
        seen_acc     = seen_q;
        if (capture) begin
            shadow_d[dig_idx]     = dec.bcd;
            shadow_inv_d[dig_idx] = dec.invalid;
            seen_acc[dig_idx]     = 1'b1;
        end

        if (capture) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TOW'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        out_d         = out_q;
        invalid_d     = invalid_q;
        frame_valid_d = 1'b0;
        stale_d       = stale_q;
        seen_d        = seen_acc;

        // The completing capture is folded straight into the frame, so nothing can be lost.
        if (seen_acc == 4'hF) begin
            out_d         = shadow_d;
            invalid_d     = shadow_inv_d;
            frame_valid_d = 1'b1;
            stale_d       = 1'b0;
            seen_d        = '0;
        end else if (!capture && tmo_cnt_q == TMO_PRE) begin
            stale_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            stab_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            seen_q        <= '0;
            shadow_q      <= {4{SEG_BLANK_BCD}};
            shadow_inv_q  <= '0;
            out_q         <= {4{SEG_BLANK_BCD}};
            invalid_q     <= '0;
            frame_valid_q <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            stab_cnt_q    <= stab_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            shadow_inv_q  <= shadow_inv_d;
            out_q         <= out_d;
            invalid_q     <= invalid_d;
            frame_valid_q <= frame_valid_d;
            stale_q       <= stale_d;
        end
    end

    assign out3        = out_q[3];
    assign out2        = out_q[2];
    assign out1        = out_q[1];
    assign out0        = out_q[0];
    assign invalid     = invalid_q;
    assign frame_valid = frame_valid_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios plus randomized scans against a dwell-level model.
module tb_seg7_scan_capture;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 1000;
    localparam int DW      = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an_in;
    logic [6:0] seg_in;
    logic [3:0] out3, out2, out1, out0, invalid;
    logic       frame_valid, stale;

    seg7_scan_capture #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .out3        (out3),
        .out2        (out2),
        .out1        (out1),
        .out0        (out0),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] o3, o2, o1, o0, inv;
    } frame_t;

    frame_t obs_q[$];
    frame_t exp_q[$];

    // ---------------- monitor ----------------
    logic        fv_prev = 1'b0;
    logic        stale_prev = 1'b1;
    logic        rst_prev = 1'b0;
    logic [19:0] outs_prev = '0;
    logic [19:0] outs_now;
    int          fv_double = 0;
    int          out_change_err = 0;
    int          stale_rise_cyc = -1;

    always @(negedge clk) begin
        outs_now = {out3, out2, out1, out0, invalid};
        if (frame_valid === 1'b1)
            obs_q.push_back('{cyc: cyc, o3: out3, o2: out2, o1: out1, o0: out0, inv: invalid});
        if (frame_valid === 1'b1 && fv_prev === 1'b1) fv_double++;
        if (rst && rst_prev && frame_valid !== 1'b1 && outs_now !== outs_prev) out_change_err++;
        if (rst && stale === 1'b1 && stale_prev !== 1'b1) stale_rise_cyc = cyc;
        fv_prev    = frame_valid;
        stale_prev = stale;
        rst_prev   = rst;
        outs_prev  = outs_now;
    end

    // ---------------- reference model (dwell level) ----------------
    logic [6:0]  legal_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  m_shadow [4];
    logic        m_inv [4];
    logic [3:0]  m_seen;
    logic [10:0] m_last_val;
    int          m_run_start, m_run_len, m_last_cap;
    bit          m_captured;

    task automatic m_decode(input logic [6:0] p, output logic [3:0] bcd, output logic inv);
        bcd = 4'hE;
        inv = 1'b1;
        if (p == 7'h7F) begin
            bcd = 4'hF;
            inv = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (p == legal_pat[i]) begin
                bcd = 4'(i);
                inv = 1'b0;
            end
        end
    endtask

    task automatic model_reset(input int release_cyc);
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'hF;
            m_inv[i]    = 1'b0;
        end
        m_seen      = 4'h0;
        m_last_val  = 11'h0;
        m_run_start = release_cyc;
        m_run_len   = 0;
        m_captured  = 1'b0;
        m_last_cap  = release_cyc - 1;
    endtask

    // A value held for at least STABLE cycles with one anode low is captured once, STABLE+1 cycles
    // after it reaches the pins; the frame appears the cycle after the completing capture.
    task automatic model_push(input logic [3:0] an, input logic [6:0] seg, input int len, input int start);
        int         c;
        int         idx;
        logic [3:0] bcd;
        logic       inv;
        if ({an, seg} == m_last_val) begin
            m_run_len += len;
        end else begin
            m_last_val  = {an, seg};
            m_run_start = start;
            m_run_len   = len;
            m_captured  = 1'b0;
        end
        if (!m_captured && $countones(~an) == 1 && m_run_len >= STABLE) begin
            m_captured = 1'b1;
            c = m_run_start + STABLE + 1;
            if (c > m_last_cap + TIMEOUT) m_seen = 4'h0;
            m_last_cap = c;
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            m_decode(seg, bcd, inv);
            m_shadow[idx] = bcd;
            m_inv[idx]    = inv;
            m_seen[idx]   = 1'b1;
            if (m_seen == 4'hF) begin
                exp_q.push_back('{cyc: c + 1, o3: m_shadow[3], o2: m_shadow[2], o1: m_shadow[1],
                                  o0: m_shadow[0], inv: {m_inv[3], m_inv[2], m_inv[1], m_inv[0]}});
                m_seen = 4'h0;
            end
        end
    endtask

    function automatic int frames_diff(output string msg);
        int n;
        n   = 0;
        msg = "";
        if (exp_q.size() != obs_q.size()) begin
            n++;
            msg = $sformatf("frame count actual=%0d required=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].o3 !== exp_q[i].o3 ||
                    obs_q[i].o2 !== exp_q[i].o2 || obs_q[i].o1 !== exp_q[i].o1 ||
                    obs_q[i].o0 !== exp_q[i].o0 || obs_q[i].inv !== exp_q[i].inv) begin
                    if (n == 0)
                        msg = $sformatf("frame %0d actual cyc=%0d %h%h%h%h inv=%b required cyc=%0d %h%h%h%h inv=%b",
                                        i, obs_q[i].cyc, obs_q[i].o3, obs_q[i].o2, obs_q[i].o1, obs_q[i].o0,
                                        obs_q[i].inv, exp_q[i].cyc, exp_q[i].o3, exp_q[i].o2, exp_q[i].o1,
                                        exp_q[i].o0, exp_q[i].inv);
                    n++;
                end
            end
        end
        return n;
    endfunction

    // ---------------- drivers ----------------
    task automatic flush();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int len);
        an_in  = an;
        seg_in = seg;
        model_push(an, seg, len, cyc);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d, input logic [6:0] seg, input int len);
        drive(~(4'b0001 << d), seg, len);
    endtask

    task automatic idle(input int len);
        drive(4'hF, 7'h7F, len);
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return legal_pat[$urandom_range(0, 9)];
        if (r == 8) return 7'h7F;
        return 7'($urandom_range(0, 127));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out3, out2, out1, out0} !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_outs: actual=%h required=ffff", {out3, out2, out1, out0});
        end
        checks++;
        if (invalid !== 4'h0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: actual inv=%b fv=%b required inv=0000 fv=0", invalid, frame_valid);
        end
        checks++;
        if (stale !== 1'b1) begin
            failures++;
            $display("FAIL reset_stale: actual=%b required=1", stale);
        end
        rst = 1'b1;
        model_reset(cyc);
        idle(10);
    endtask

    task automatic test_basic_frame();
        int    t9;
        string msg;
        flush();
        checks++;
        if (stale !== 1'b1) begin
            failures++;
            $display("FAIL basic_stale_before: actual=%b required=1", stale);
        end
        drive_digit(0, 7'h30, DW);
        drive_digit(1, 7'h79, DW);
        drive_digit(2, 7'h19, DW);
        t9 = cyc;
        drive_digit(3, 7'h10, DW);
        idle(DW);
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL basic_model: %s", msg);
        end
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL basic_count: actual=%0d required=1", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[0].o3, obs_q[0].o2, obs_q[0].o1, obs_q[0].o0, obs_q[0].inv} !== 20'h94130) begin
                failures++;
                $display("FAIL basic_values: actual=%h%h%h%h inv=%b required=9413 inv=0000",
                         obs_q[0].o3, obs_q[0].o2, obs_q[0].o1, obs_q[0].o0, obs_q[0].inv);
            end
            checks++;
            if (obs_q[0].cyc != t9 + STABLE + 2) begin
                failures++;
                $display("FAIL basic_latency: actual=%0d required=%0d", obs_q[0].cyc, t9 + STABLE + 2);
            end
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL basic_stale_after: actual=%b required=0", stale);
        end
    endtask

    task automatic test_illegal();
        string msg;
        flush();
        drive_digit(0, 7'h40, DW);
        drive_digit(1, 7'h00, DW);
        drive_digit(2, 7'h7E, DW);
        drive_digit(3, 7'h7F, DW);
        idle(DW);
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL illegal_model: %s", msg);
        end
        checks++;
        if ({out3, out2, out1, out0} !== 16'hFE80 || invalid !== 4'b0100) begin
            failures++;
            $display("FAIL illegal_values: actual=%h%h%h%h inv=%b required=fe80 inv=0100",
                     out3, out2, out1, out0, invalid);
        end
    endtask

    task automatic test_glitch();
        string msg;
        flush();
        drive_digit(0, 7'h12, 8);
        drive_digit(0, 7'h78, 10);
        drive_digit(0, 7'h12, 30);
        drive_digit(1, 7'h79, DW);
        drive_digit(2, 7'h24, DW);
        drive_digit(3, 7'h30, DW);
        idle(DW);
        checks++;
        if (out0 !== 4'd5) begin
            failures++;
            $display("FAIL glitch_short: actual=%h required=5", out0);
        end
        drive_digit(0, 7'h12, 20);
        drive_digit(0, 7'h02, 17);
        drive_digit(1, 7'h79, DW);
        drive_digit(2, 7'h24, DW);
        drive_digit(3, 7'h30, DW);
        idle(DW);
        checks++;
        if (out0 !== 4'd6) begin
            failures++;
            $display("FAIL glitch_long: actual=%h required=6", out0);
        end
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL glitch_model: %s", msg);
        end
    endtask

    task automatic test_no_active();
        string msg;
        flush();
        drive(4'b1100, 7'h30, 100);
        drive(4'b1111, 7'h30, 100);
        drive_digit(1, 7'h79, DW);
        drive_digit(2, 7'h24, DW);
        drive_digit(3, 7'h30, DW);
        idle(DW);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL no_active_capture: actual frames=%0d required=0", obs_q.size());
        end
        drive_digit(0, 7'h40, DW);
        idle(DW);
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL no_active_model: %s", msg);
        end
        checks++;
        if ({out3, out2, out1, out0} !== 16'h3210) begin
            failures++;
            $display("FAIL no_active_values: actual=%h%h%h%h required=3210", out3, out2, out1, out0);
        end
    endtask

    task automatic test_timeout();
        logic [19:0] held;
        int          want_rise;
        string       msg;
        flush();
        held           = {out3, out2, out1, out0, invalid};
        want_rise      = m_last_cap + TIMEOUT + 1;
        stale_rise_cyc = -1;
        idle(TIMEOUT + 20);
        checks++;
        if (stale !== 1'b1 || stale_rise_cyc != want_rise) begin
            failures++;
            $display("FAIL timeout_stale: actual stale=%b rise=%0d required stale=1 rise=%0d",
                     stale, stale_rise_cyc, want_rise);
        end
        checks++;
        if ({out3, out2, out1, out0, invalid} !== held) begin
            failures++;
            $display("FAIL timeout_hold: actual=%h required=%h", {out3, out2, out1, out0, invalid}, held);
        end
        drive_digit(0, 7'h12, DW);
        drive_digit(1, 7'h02, DW);
        idle(TIMEOUT + 20);
        drive_digit(2, 7'h78, DW);
        drive_digit(3, 7'h00, DW);
        idle(DW);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_partial: actual frames=%0d required=0", obs_q.size());
        end
        drive_digit(0, 7'h12, DW);
        drive_digit(1, 7'h02, DW);
        idle(DW);
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL timeout_model: %s", msg);
        end
        checks++;
        if ({out3, out2, out1, out0} !== 16'h8765 || stale !== 1'b0) begin
            failures++;
            $display("FAIL timeout_resume: actual=%h%h%h%h stale=%b required=8765 stale=0",
                     out3, out2, out1, out0, stale);
        end
    endtask

    task automatic test_reset_midframe();
        string msg;
        flush();
        drive_digit(0, 7'h79, DW);
        drive_digit(1, 7'h24, DW);
        drive_digit(2, 7'h30, DW);
        idle(5);
        rst = 1'b0;
        #2;
        checks++;
        if ({out3, out2, out1, out0, invalid} !== 20'hFFFF0 || stale !== 1'b1 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outs: actual=%h stale=%b fv=%b required=ffff0 stale=1 fv=0",
                     {out3, out2, out1, out0, invalid}, stale, frame_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset(cyc);
        idle(5);
        drive_digit(3, 7'h19, DW);
        idle(DW);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_partial: actual frames=%0d required=0", obs_q.size());
        end
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL midreset_model: %s", msg);
        end
    endtask

    task automatic test_back_to_back();
        int         order [4];
        int         j, tmp;
        logic [6:0] p;
        string      msg;
        flush();
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 4; k++) order[k] = k;
            for (int k = 3; k > 0; k--) begin
                j        = $urandom_range(0, k);
                tmp      = order[k];
                order[k] = order[j];
                order[j] = tmp;
            end
            for (int k = 0; k < 4; k++) begin
                p = rand_pat();
                if ($urandom_range(0, 3) == 0) begin
                    drive_digit(order[k], p, $urandom_range(2, 8));
                    drive_digit(order[k], 7'($urandom_range(0, 127)), $urandom_range(1, STABLE - 1));
                end
                drive_digit(order[k], p, $urandom_range(STABLE, STABLE + 20));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(DW);
        checks++;
        if (obs_q.size() != 20) begin
            failures++;
            $display("FAIL b2b_count: actual=%0d required=20", obs_q.size());
        end
        checks++;
        if (frames_diff(msg) != 0) begin
            failures++;
            $display("FAIL b2b_model: %s", msg);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (fv_double != 0) begin
            failures++;
            $display("FAIL fv_consecutive: actual=%0d required=0", fv_double);
        end
        checks++;
        if (out_change_err != 0) begin
            failures++;
            $display("FAIL out_change_without_fv: actual=%0d required=0", out_change_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_illegal();
        test_glitch();
        test_no_active();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the 4-digit multiplexed 7-segment display driver. Samples a time-multiplexed anode/segment bus, decodes each digit's segment pattern back to BCD and publishes a coherent 4-digit frame once every digit has been seen stably. Used as an on-board loopback checker for display output and as a scoreboard front-end in system benches.

## Interface
- `STABLE`, 16: consecutive cycles a synchronized {an, seg} value must hold before its digit is captured (≥2).
- `TIMEOUT`, 10_000_000: cycles without any capture before `stale` asserts.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-low.
- `an_in` in 4: anode enables, active-low, one-hot-low when scanning; bit i selects digit i.
- `seg_in` in 7: segments, active-low, {g,f,e,d,c,b,a}.
- `out3`..`out0` out 4 each: captured BCD digits of the last complete frame.
- `invalid` out 4: bit i set if digit i's pattern in the last frame was not a legal code.
- `frame_valid` out 1: one-cycle pulse when `out*`/`invalid` update.
- `stale` out 1: no complete frame since reset or since timeout.

## Operation
- `an_in`, `seg_in` pass through a 2-flop synchronizer; all logic below uses the synchronized values.
- Legal encodings (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank 7F decodes to 4'hF with no error; any other pattern decodes to 4'hE and marks invalid.
- Active digit: exactly one `an` bit low. Zero or multiple low → no active digit; stability counter cleared, nothing captured.
- Stability counter: increments while synchronized {an, seg} equals its previous-cycle value, clears on any change. When it reaches `STABLE`-1 (i.e. `STABLE`-th consecutive equal sample) with an active digit, the decoded value and invalid flag are written to that digit's shadow register and its bit set in `seen[3:0]`. Counter saturates; each dwell captures once.
- Frame: when `seen` becomes 4'b1111, next cycle: shadow → `out*`/`invalid`, `frame_valid`=1, `stale`=0, `seen` cleared. A capture in that same cycle sets its `seen` bit after the clear (no capture lost).
- Re-capture of an already-seen digit before frame completion overwrites its shadow (latest value wins).
- Timeout counter: cleared on every capture, else increments; on reaching `TIMEOUT`, `stale`=1, `seen` cleared, outputs hold last values. Counter saturates.

## Timing
- Reset values: `out3..out0`=4'hF, `invalid`=0, `frame_valid`=0, `stale`=1; synchronizers, shadows (4'hF), `seen`, counters all cleared. Reset mid-frame discards partial frame.
- Latency: pin value settled at cycle 0 → capture at cycle 2+`STABLE`-1 → if it completes the frame, `frame_valid` and outputs change at cycle 2+`STABLE`.
- `frame_valid` never high two consecutive cycles; outputs change only with `frame_valid`.
- Glitch shorter than `STABLE` cycles on seg or an: never captured.

## Structure
- Package `seg7_pkg`: segment encoding constants for 0-9 and blank, `SEG_BLANK_BCD`=4'hF, `SEG_ERR_BCD`=4'hE, segment bit-order definition; shared with the display driver side.
- Sub-module `seg7_to_bcd`: combinational 7-bit pattern → {bcd[3:0], invalid}; top holds synchronizer, counters, `seen` mask and frame registers.

## Test plan
- Drive digits 3,1,4,9 (an 1110/1101/1011/0111, seg 30/79/19/10), 40-cycle dwells, `STABLE`=16 → `frame_valid` pulse, `out3..0`=9,4,1,3, `invalid`=0, `stale` 1→0.
- Digit 2 pattern 7'h7E (illegal) → `out2`=4'hE, `invalid`=4'b0100; pattern 7F → 4'hF, no invalid.
- 10-cycle glitch on seg during digit 0 dwell → captured value is pre-glitch digit; 17-cycle change → new value captured.
- `an_in`=4'b1100 or 4'b1111 for 100 cycles → no capture, no `frame_valid`.
- Stop scanning after one frame, `TIMEOUT`=1000 → `stale`=1 at cycle 1000 after last capture, outputs hold; resume → next full frame clears `stale`.
- Assert `rst` after 3 digits captured → all outputs reset values; 4th digit alone produces no `frame_valid`.
